// File: rtl/div_pkg.sv
// Shared types, default sizes and sign helpers for the iterative divider.
package div_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_e;

    function automatic logic [DIV_WIDTH-1:0] div_neg(input logic [DIV_WIDTH-1:0] x);
        return ~x + 1'b1;
    endfunction

    // Unsigned magnitude: the most negative value maps onto itself, which is correct unsigned.
    function automatic logic [DIV_WIDTH-1:0] div_abs(input logic [DIV_WIDTH-1:0] x);
        return x[DIV_WIDTH-1] ? div_neg(x) : x;
    endfunction

endpackage

// File: rtl/div_seq_step.sv
// One restoring shift-subtract iteration, purely combinational.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   a_i,
    input  logic [WIDTH-1:0] q_i,
    input  logic [WIDTH-1:0] m_i,
    output logic [WIDTH:0]   a_o,
    output logic [WIDTH-1:0] q_o
);

    logic [2*WIDTH:0] shifted;
    logic [WIDTH:0]   trial;

    always_comb begin
        shifted = {a_i, q_i} << 1;
        trial   = shifted[2*WIDTH:WIDTH] - {1'b0, m_i};
        if (trial[WIDTH]) begin
            a_o = shifted[2*WIDTH:WIDTH];
            q_o = shifted[WIDTH-1:0];
        end else begin
            a_o = trial;
            q_o = shifted[WIDTH-1:0] | {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/div_seq.sv
// Iterative signed divider sequencer: latch, WIDTH restoring steps, sign fix, RDY pulse.
// Optional signed remainder output enabled by DIV_REMAINDER_EN.
module div_seq
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = DIV_CNT_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
`ifdef DIV_REMAINDER_EN
    ,
    output logic [WIDTH-1:0] data_remainder
`endif
);

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    div_state_e       state_q, state_d;
    logic             sign_a_q, sign_a_d;
    logic             sign_b_q, sign_b_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH:0]   a_q, a_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             exc_q, exc_d;
    logic [WIDTH:0]   step_a;
    logic [WIDTH-1:0] step_q;
`ifdef DIV_REMAINDER_EN
    logic [WIDTH-1:0] rem_q, rem_d;
`endif

    div_step #(.WIDTH(WIDTH)) u_step (
        .a_i (a_q),
        .q_i (q_q),
        .m_i (m_q),
        .a_o (step_a),
        .q_o (step_q)
    );

    always_comb begin
        state_d  = state_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        q_d      = q_q;
        m_d      = m_q;
        a_d      = a_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        exc_d    = exc_q;
`ifdef DIV_REMAINDER_EN
        rem_d    = rem_q;
`endif
        // A start pulse wins in every state, so a restart silently discards the running operation.
        if (ctrl_DIV) begin
            sign_a_d = data_operandA[WIDTH-1];
            sign_b_d = data_operandB[WIDTH-1];
            q_d      = div_abs(data_operandA);
            m_d      = div_abs(data_operandB);
            a_d      = '0;
            cnt_d    = '0;
            if (data_operandB == '0) begin
                state_d  = DONE;
                result_d = '0;
                exc_d    = 1'b1;
`ifdef DIV_REMAINDER_EN
                rem_d    = '0;
`endif
            end else begin
                state_d = RUN;
            end
        end else begin
            case (state_q)
                RUN: begin
                    a_d   = step_a;
                    q_d   = step_q;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_STEP) state_d = FIX;
                end
                FIX: begin
                    result_d = (sign_a_q ^ sign_b_q) ? div_neg(q_q) : q_q;
                    exc_d    = 1'b0;
`ifdef DIV_REMAINDER_EN
                    rem_d    = sign_a_q ? div_neg(a_q[WIDTH-1:0]) : a_q[WIDTH-1:0];
`endif
                    state_d  = DONE;
                end
                DONE:    state_d = IDLE;
                IDLE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            q_q      <= '0;
            m_q      <= '0;
            a_q      <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            exc_q    <= 1'b0;
`ifdef DIV_REMAINDER_EN
            rem_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            q_q      <= q_d;
            m_q      <= m_d;
            a_q      <= a_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            exc_q    <= exc_d;
`ifdef DIV_REMAINDER_EN
            rem_q    <= rem_d;
`endif
        end
    end

    assign data_result    = result_q;
    assign data_exception = exc_q;
    assign data_resultRDY = (state_q == DONE);
    assign busy           = (state_q != IDLE);
`ifdef DIV_REMAINDER_EN
    assign data_remainder = rem_q;
`endif

endmodule

// File: tb/tb_div_seq.sv
// Scoreboard bench for div_seq: stimulus pushes expected results, a negedge monitor pops on RDY.
module tb_div_seq;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ctrl_DIV;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;
`ifdef DIV_REMAINDER_EN
    logic [31:0] data_remainder;
`endif

    div_seq #(.WIDTH(32), .CNT_W(6)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
`ifdef DIV_REMAINDER_EN
        ,
        .data_remainder (data_remainder)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] quo;
        logic        exc;
        logic [31:0] rem;
        int          due_min;
        int          due_max;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: plain signed arithmetic, truncating quotient, remainder takes dividend's sign.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int sa, sb_;
        sa = a;
        sb_ = b;
        e.due_min = 0;
        e.due_max = 0;
        if (b == 32'd0) begin
            e.quo = 32'd0; e.exc = 1'b1; e.rem = 32'd0;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.quo = 32'h8000_0000; e.exc = 1'b0; e.rem = 32'd0;
        end else begin
            e.quo = sa / sb_; e.exc = 1'b0; e.rem = sa % sb_;
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (data_resultRDY) begin
            if (sb.size() == 0) begin
                check("unexpected_rdy", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("quotient", data_result, e.quo);
                check("exception", {31'd0, data_exception}, {31'd0, e.exc});
`ifdef DIV_REMAINDER_EN
                check("remainder", data_remainder, e.rem);
`endif
                check("rdy_in_window",
                      {31'd0, (cyc >= e.due_min && cyc <= e.due_max)}, 32'd1);
            end
        end
    end

    // Drive one start pulse; returns the cycle index in which ctrl_DIV was high.
    task automatic start(input logic [31:0] a, input logic [31:0] b, input bit track,
                         output int s);
        exp_t e;
        ctrl_DIV      = 1'b1;
        data_operandA = a;
        data_operandB = b;
        s = cyc;
        if (track) begin
            e = model(a, b);
            e.due_min = s + ((b == 32'd0) ? 1 : 34);
            e.due_max = s + ((b == 32'd0) ? 2 : 34);
            sb.push_back(e);
        end
        @(negedge clk);
        ctrl_DIV      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            check("rdy_timeout", 32'd1, 32'd0);
            sb.delete();
        end
        @(negedge clk);
    endtask

    logic [31:0] dir_a[5] = '{32'd100, 32'hFFFF_FF9C, 32'd100, 32'd5, 32'h8000_0000};
    logic [31:0] dir_b[5] = '{32'd7, 32'd7, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF};

    initial begin
        int s;
        logic [31:0] a, b;
        reset_n       = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        repeat (3) @(negedge clk);
        check("reset_result", data_result, 32'd0);
        check("reset_exc", {31'd0, data_exception}, 32'd0);
        check("reset_rdy", {31'd0, data_resultRDY}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Directed: 100/7 with busy profile, mixed signs, divide by zero, overflow.
        start(dir_a[0], dir_b[0], 1'b1, s);
        check("busy_first", {31'd0, busy}, 32'd1);
        while (cyc < s + 34) @(negedge clk);
        check("busy_last", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check("busy_after", {31'd0, busy}, 32'd0);
        for (int i = 1; i < 5; i++) begin
            start(dir_a[i], dir_b[i], 1'b1, s);
            drain(60);
        end

        // Restart at cycle 10 of 100/7 with 63/9: only the second result appears.
        start(32'd100, 32'd7, 1'b0, s);
        while (cyc < s + 10) @(negedge clk);
        start(32'd63, 32'd9, 1'b1, s);
        drain(60);

        // Reset at cycle 15 of 100/7: outputs clear and no RDY follows.
        start(32'd100, 32'd7, 1'b0, s);
        while (cyc < s + 15) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        check("midreset_result", data_result, 32'd0);
        check("midreset_exc", {31'd0, data_exception}, 32'd0);
        check("midreset_busy", {31'd0, busy}, 32'd0);
        check("midreset_rdy", {31'd0, data_resultRDY}, 32'd0);
        repeat (40) @(negedge clk);

        // Random operands with a bias toward small divisors and edge values.
        for (int i = 0; i < 200; i++) begin
            case ($urandom_range(0, 5))
                0:       a = $urandom_range(0, 1000);
                1:       a = 32'h8000_0000;
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       b = 32'hFFFF_FFFF;
                2:       b = $urandom_range(1, 20);
                3:       b = -$urandom_range(1, 20);
                4:       b = 32'h8000_0000;
                default: b = $urandom;
            endcase
            start(a, b, 1'b1, s);
            drain(60);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
